halt_snapshot_unit: RTL and testbench
=====================================

HALT_SNAPSHOT_UNIT -- requirements
Module: halt_snapshot_unit

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width, minimum 32; NREGS, default 32, register-file depth, power of 2; NUM_BP, default 2, breakpoint comparator count, 1..8; MAX_CYCLES, default 1000, watchdog limit in retired PCs, at least 1.
REQ-002 Clock and reset SHALL be asynchronous active-low: clk input 1, rising-edge clock; rstn input 1, reset active when 0.
REQ-003 pc_i input XLEN; address of the instruction retiring this cycle.
REQ-004 pc_valid_i input 1; pc_i is meaningful this cycle.
REQ-005 arm_i input 1; single-cycle pulse that starts or re-arms the monitor.
REQ-006 bp_en_i input NUM_BP; per-comparator enable.
REQ-007 bp_addr_i input NUM_BP*XLEN; comparator k uses slice [k*XLEN +: XLEN].
REQ-008 reg_sel_o output log2(NREGS); register-file read select.
REQ-009 reg_data_i input XLEN; combinational register-file read data for reg_sel_o.
REQ-010 halt_o output 1; stall request to the core.
REQ-011 dump_valid_o output 1; dump_data_o output XLEN; dump_last_o output 1; dump_ready_i input 1; snapshot stream.
REQ-012 busy_o output 1; high in RUN or DUMP.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, DUMP and DONE.
REQ-014 IDLE: arm_i SHALL go to RUN and clear the cycle counter and cause.
REQ-015 RUN: each pc_valid_i cycle SHALL increment the counter, saturating at 2^16-1.
REQ-016 Breakpoint hit: pc_valid_i and bp_en_i[k] and pc_i == bp_addr_i[k]; the lowest k SHALL win.
REQ-017 Timeout: a pc_valid_i cycle whose increment makes the counter equal MAX_CYCLES.
REQ-018 On a hit or a timeout, the FSM SHALL latch pc_i, the counter value after increment, a bp flag, a timeout flag and the winning index, then go to DUMP next cycle.
REQ-019 If a hit and a timeout occur in the same cycle, both flags SHALL be set.
REQ-020 halt_o SHALL be registered, asserting the cycle after the trigger and staying high through DUMP and DONE until arm_i is accepted.
REQ-021 DUMP SHALL emit NREGS+2 beats with valid/ready semantics: beat 0 is the latched PC; beat 1 is the cause word; beats 2..NREGS+1 are register idx-2.
REQ-022 Cause word fields: [0] bp, [1] timeout, [4:2] bp index, [31:16] cycle count, all other bits 0.
REQ-023 During register beats, reg_sel_o SHALL equal idx-2 and dump_data_o SHALL equal reg_data_i; register 0 SHALL always read as 0.
REQ-024 A beat SHALL advance only when dump_valid_o && dump_ready_i.
REQ-025 dump_data_o and reg_sel_o SHALL be held stable while dump_ready_i is low.
REQ-026 dump_last_o SHALL be high only on beat NREGS+1; its handshake SHALL go to DONE.
REQ-027 DONE: arm_i SHALL go to RUN, clear the counter and cause, and deassert halt_o the next cycle.
REQ-028 arm_i SHALL be ignored in RUN and DUMP.
REQ-029 pc_valid_i SHALL be ignored outside RUN.
REQ-030 reg_sel_o SHALL be 0 outside DUMP.

Reset
REQ-031 Asserting rstn low SHALL asynchronously force IDLE, halt_o=0, dump_valid_o=0, dump_last_o=0, busy_o=0, reg_sel_o=0, dump_data_o=0, counter=0, beat index=0 and cause=0.
REQ-032 A reset mid-DUMP SHALL abort the stream with no further beats.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the cause-word bit positions and the beat-index constants (PC beat 0, cause beat 1, first register beat 2).
REQ-034 A sub-module bp_match SHALL hold the comparator array with the lowest-index priority encoder, outputting hit and index; it SHALL be combinational.

Verification
REQ-035 Breakpoint: NUM_BP=2, bp0=0x310 enabled; pc 0,4,...,0x310 valid every cycle -> halt_o the cycle after 0x310; beat0=0x00000310; beat1=0x00C50001 (count 197); 34 beats; last on beat 33.
REQ-036 Timeout: no bp enabled, MAX_CYCLES=1000, pc_valid_i continuously -> trigger on the 1000th valid cycle; cause=0x03E80002.
REQ-037 Simultaneous: MAX_CYCLES=4, bp1=0xC enabled, pc 0,4,8,C -> cause=0x00040007.
REQ-038 Backpressure: dump_ready_i toggling 1,0,0,1 -> no beat lost or duplicated; data stable while stalled; register 5 preloaded 0xDEADBEEF appears on beat 7.
REQ-039 Reset mid-DUMP: rstn low at beat 10 -> dump_valid_o and halt_o go 0 immediately; state IDLE; arm_i during DUMP has no effect.
REQ-040 Re-arm: arm_i in DONE -> halt_o low next cycle, counter restarts at 0, and a second breakpoint produces a fresh snapshot.

Source files
------------

// File: rtl/halt_snapshot_unit_pkg.sv
// Shared types and constants for the halt/snapshot debug monitor.
package halt_snapshot_unit_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Retired-PC counter width and its saturation value
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  // Cause word bit positions
  localparam int unsigned CAUSE_BP_BIT  = 0;
  localparam int unsigned CAUSE_TO_BIT  = 1;
  localparam int unsigned CAUSE_IDX_LSB = 2;
  localparam int unsigned CAUSE_IDX_W   = 3;
  localparam int unsigned CAUSE_CNT_LSB = 16;
  localparam int unsigned CAUSE_W       = 32;

  // Snapshot beat indices
  localparam int unsigned BEAT_PC    = 0;
  localparam int unsigned BEAT_CAUSE = 1;
  localparam int unsigned BEAT_REG0  = 2;

  // Pack the halt cause into its 32-bit word; unused bits stay zero
  function automatic logic [CAUSE_W-1:0] make_cause(
    input logic                   bp,
    input logic                   to,
    input logic [CAUSE_IDX_W-1:0] idx,
    input logic [CNT_W-1:0]       cnt
  );
    logic [CAUSE_W-1:0] w;
    w = '0;
    w[CAUSE_BP_BIT] = bp;
    w[CAUSE_TO_BIT] = to;
    w[CAUSE_IDX_LSB +: CAUSE_IDX_W] = idx;
    w[CAUSE_CNT_LSB +: CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/halt_snapshot_unit_if.sv
// Snapshot stream: valid/ready beats with a last marker.
interface halt_snapshot_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            dump_valid_o;
  logic [XLEN-1:0] dump_data_o;
  logic            dump_last_o;
  logic            dump_ready_i;

  modport master (
    output dump_valid_o,
    output dump_data_o,
    output dump_last_o,
    input  dump_ready_i
  );

  modport slave (
    input  dump_valid_o,
    input  dump_data_o,
    input  dump_last_o,
    output dump_ready_i
  );

endinterface

// File: rtl/halt_snapshot_unit_bp_match.sv
// Breakpoint comparator array with lowest-index-wins priority.
module bp_match
  import halt_snapshot_unit_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_BP = 2
) (
  input  logic [XLEN-1:0]        i_pc,
  input  logic                   i_pc_valid,
  input  logic [NUM_BP-1:0]      i_bp_en,
  input  logic [NUM_BP*XLEN-1:0] i_bp_addr,
  output logic                   o_hit_c,
  output logic [CAUSE_IDX_W-1:0] o_idx_c
);

  // Scan from the top down so the lowest matching comparator is the last write
  always_comb begin
    o_hit_c = 1'b0;
    o_idx_c = '0;
    for (int k = NUM_BP - 1; k >= 0; k--) begin
      if (i_pc_valid && i_bp_en[k] && (i_bp_addr[k*XLEN +: XLEN] == i_pc)) begin
        o_hit_c = 1'b1;
        o_idx_c = CAUSE_IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/halt_snapshot_unit.sv
// Debug monitor: watches retired PCs, halts the core on a breakpoint or
// watchdog timeout, then streams PC, cause and register file out.
module halt_snapshot_unit
  import halt_snapshot_unit_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned NUM_BP     = 2,
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [XLEN-1:0]           pc_i,
  input  logic                      pc_valid_i,
  input  logic                      arm_i,
  input  logic [NUM_BP-1:0]         bp_en_i,
  input  logic [NUM_BP*XLEN-1:0]    bp_addr_i,
  output logic [$clog2(NREGS)-1:0]  reg_sel_o,
  input  logic [XLEN-1:0]           reg_data_i,
  output logic                      halt_o,
  output logic                      busy_o,
  halt_snapshot_unit_if.master      dump
);

  localparam int unsigned RSEL_W    = $clog2(NREGS);
  localparam int unsigned BEAT_W    = $clog2(NREGS + 2);
  localparam int unsigned LAST_BEAT = NREGS + 1;

  state_e                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [XLEN-1:0]        r_pc, w_pc_nxt;
  logic                   r_cause_bp, w_cause_bp_nxt;
  logic                   r_cause_to, w_cause_to_nxt;
  logic [CAUSE_IDX_W-1:0] r_cause_idx, w_cause_idx_nxt;
  logic [CNT_W-1:0]       r_cause_cnt, w_cause_cnt_nxt;
  logic [BEAT_W-1:0]      r_beat, w_beat_nxt;
  logic [RSEL_W-1:0]      r_reg_sel, w_reg_sel_nxt;
  logic                   r_halt, w_halt_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_last, w_last_nxt;

  logic                   w_hit;
  logic [CAUSE_IDX_W-1:0] w_bp_idx;
  logic                   w_timeout;
  logic [XLEN-1:0]        w_dump_data;

  bp_match #(
    .XLEN   (XLEN),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .i_pc       (pc_i),
    .i_pc_valid (pc_valid_i),
    .i_bp_en    (bp_en_i),
    .i_bp_addr  (bp_addr_i),
    .o_hit_c    (w_hit),
    .o_idx_c    (w_bp_idx)
  );

  // Saturating retired-PC count and watchdog compare on the incremented value
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout = pc_valid_i && (32'(w_cnt_inc) == 32'(MAX_CYCLES));

  // Next-state, capture and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pc_nxt        = r_pc;
    w_cause_bp_nxt  = r_cause_bp;
    w_cause_to_nxt  = r_cause_to;
    w_cause_idx_nxt = r_cause_idx;
    w_cause_cnt_nxt = r_cause_cnt;
    w_beat_nxt      = r_beat;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (arm_i) begin
          w_state_nxt     = ST_RUN;
          w_cnt_nxt       = '0;
          w_cause_bp_nxt  = 1'b0;
          w_cause_to_nxt  = 1'b0;
          w_cause_idx_nxt = '0;
          w_cause_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        if (pc_valid_i) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_hit || w_timeout) begin
            w_pc_nxt        = pc_i;
            w_cause_bp_nxt  = w_hit;
            w_cause_to_nxt  = w_timeout;
            w_cause_idx_nxt = w_bp_idx;
            w_cause_cnt_nxt = w_cnt_inc;
            w_beat_nxt      = '0;
            w_state_nxt     = ST_DUMP;
          end
        end
      end
      ST_DUMP: begin
        if (r_valid && dump.dump_ready_i) begin
          if (r_beat == BEAT_W'(LAST_BEAT)) begin
            w_beat_nxt  = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_halt_nxt  = (w_state_nxt == ST_DUMP) || (w_state_nxt == ST_DONE);
    w_busy_nxt  = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DUMP);
    w_valid_nxt = (w_state_nxt == ST_DUMP);
    w_last_nxt  = (w_state_nxt == ST_DUMP) && (w_beat_nxt == BEAT_W'(LAST_BEAT));
    w_reg_sel_nxt = '0;
    if ((w_state_nxt == ST_DUMP) && (w_beat_nxt >= BEAT_W'(BEAT_REG0))) begin
      w_reg_sel_nxt = RSEL_W'(w_beat_nxt - BEAT_W'(BEAT_REG0));
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pc        <= '0;
      r_cause_bp  <= 1'b0;
      r_cause_to  <= 1'b0;
      r_cause_idx <= '0;
      r_cause_cnt <= '0;
      r_beat      <= '0;
      r_reg_sel   <= '0;
      r_halt      <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pc        <= w_pc_nxt;
      r_cause_bp  <= w_cause_bp_nxt;
      r_cause_to  <= w_cause_to_nxt;
      r_cause_idx <= w_cause_idx_nxt;
      r_cause_cnt <= w_cause_cnt_nxt;
      r_beat      <= w_beat_nxt;
      r_reg_sel   <= w_reg_sel_nxt;
      r_halt      <= w_halt_nxt;
      r_busy      <= w_busy_nxt;
      r_valid     <= w_valid_nxt;
      r_last      <= w_last_nxt;
    end
  end

  // Beat payload; register reads pass straight through so the register
  // file's combinational data is what leaves, with register 0 forced to 0
  always_comb begin
    w_dump_data = '0;
    if (r_state == ST_DUMP) begin
      if (r_beat == BEAT_W'(BEAT_PC)) begin
        w_dump_data = r_pc;
      end else if (r_beat == BEAT_W'(BEAT_CAUSE)) begin
        w_dump_data = XLEN'(make_cause(r_cause_bp, r_cause_to, r_cause_idx, r_cause_cnt));
      end else if (r_reg_sel != '0) begin
        w_dump_data = reg_data_i;
      end
    end
  end

  assign reg_sel_o         = r_reg_sel;
  assign halt_o            = r_halt;
  assign busy_o            = r_busy;
  assign dump.dump_valid_o = r_valid;
  assign dump.dump_last_o  = r_last;
  assign dump.dump_data_o  = w_dump_data;

endmodule

// File: tb/tb_halt_snapshot_unit.sv
// Scoreboard bench for halt_snapshot_unit against a behavioural model.
module tb_halt_snapshot_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned NUM_BP  = 2;
  localparam int unsigned MAX_CYC = 1000;
  localparam int unsigned RSEL_W  = $clog2(NREGS);

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DUMP = 2;
  localparam int M_DONE = 3;

  typedef struct {
    logic [31:0]       data;
    logic              last;
    logic              is_reg;
    logic [RSEL_W-1:0] sel;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [XLEN-1:0]        pc;
  logic                   pc_valid;
  logic                   arm;
  logic [NUM_BP-1:0]      bp_en;
  logic [NUM_BP*XLEN-1:0] bp_addr;
  logic [RSEL_W-1:0]      reg_sel;
  logic [XLEN-1:0]        reg_data;
  logic                   halt;
  logic                   busy;

  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] bp_arr [NUM_BP];

  beat_t       exp_q[$];
  logic [31:0] cap_q[$];
  int          m_state;
  int          m_cnt;
  int          beats_seen;
  int          rdy_mode;
  int          errors;
  int          checks;

  halt_snapshot_unit_if #(.XLEN(XLEN)) dump_if ();

  halt_snapshot_unit #(
    .XLEN       (XLEN),
    .NREGS      (NREGS),
    .NUM_BP     (NUM_BP),
    .MAX_CYCLES (MAX_CYC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc_i       (pc),
    .pc_valid_i (pc_valid),
    .arm_i      (arm),
    .bp_en_i    (bp_en),
    .bp_addr_i  (bp_addr),
    .reg_sel_o  (reg_sel),
    .reg_data_i (reg_data),
    .halt_o     (halt),
    .busy_o     (busy),
    .dump       (dump_if)
  );

  always #5 clk = ~clk;

  assign reg_data = rf[reg_sel];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic set_bp(input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] en);
    bp_arr[0] = a0;
    bp_arr[1] = a1;
    bp_addr   = {a1, a0};
    bp_en     = en;
  endtask

  // Expected snapshot: PC, cause word, then the register file with r0 as zero
  task automatic push_snapshot(input logic [31:0] p, input bit hit, input bit to,
                               input int idx, input int cnt);
    beat_t b;
    int cause;
    cause = cnt * 65536 + idx * 4 + (to ? 2 : 0) + (hit ? 1 : 0);
    b.data = p;             b.last = 1'b0; b.is_reg = 1'b0; b.sel = '0;
    exp_q.push_back(b);
    b.data = 32'(cause);
    exp_q.push_back(b);
    for (int r = 0; r < int'(NREGS); r++) begin
      b.data   = (r == 0) ? 32'h0 : rf[r];
      b.last   = (r == int'(NREGS) - 1);
      b.is_reg = 1'b1;
      b.sel    = RSEL_W'(r);
      exp_q.push_back(b);
    end
  endtask

  // Reference behaviour for one clock edge of stimulus
  task automatic model_step(input logic v, input logic [31:0] p, input logic a);
    bit hit;
    bit to;
    int idx;
    if (a && (m_state == M_IDLE || m_state == M_DONE)) begin
      m_state = M_RUN;
      m_cnt   = 0;
    end else if (m_state == M_RUN && v) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      hit = 1'b0;
      idx = 0;
      for (int k = 0; k < int'(NUM_BP); k++) begin
        if (!hit && bp_en[k] && bp_arr[k] == p) begin
          hit = 1'b1;
          idx = k;
        end
      end
      to = (m_cnt == int'(MAX_CYC));
      if (hit || to) begin
        push_snapshot(p, hit, to, idx, m_cnt);
        m_state = M_DUMP;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] p, input logic a);
    pc_valid = v;
    pc       = p;
    arm      = a;
    model_step(v, p, a);
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
    arm      = 1'b0;
    chk("halt", 32'(halt), (m_state == M_DUMP || m_state == M_DONE) ? 32'd1 : 32'd0);
    chk("busy", 32'(busy), (m_state == M_RUN || m_state == M_DUMP) ? 32'd1 : 32'd0);
    if (m_state != M_DUMP) chk("reg_sel_idle", 32'(reg_sel), 32'd0);
  endtask

  task automatic run_seq(input logic [31:0] base, input bit gaps, input int budget);
    logic [31:0] p;
    logic v;
    int n;
    p = base;
    n = 0;
    while (m_state == M_RUN && n < budget) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle(v, p, 1'b0);
      if (v) p = p + 32'd4;
      n++;
    end
    if (m_state == M_RUN) begin
      checks++;
      errors++;
      $display("FAIL run_budget: no trigger after %0d cycles", n);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (m_state == M_DUMP && n < budget) begin
      cycle(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'b0);
      n++;
    end
    if (m_state == M_DUMP) begin
      checks++;
      errors++;
      $display("FAIL drain_budget: %0d beats still pending", exp_q.size());
    end
  endtask

  task automatic start_test(input int mode);
    cap_q.delete();
    beats_seen = 0;
    rdy_mode   = mode;
  endtask

  // Ready pattern: 0 always ready, 1 repeating 1,0,0,1, 2 random
  initial begin
    int ph;
    ph = 0;
    dump_if.dump_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       dump_if.dump_ready_i = (ph % 4 == 0) || (ph % 4 == 3);
        2:       dump_if.dump_ready_i = 1'($urandom_range(0, 1));
        default: dump_if.dump_ready_i = 1'b1;
      endcase
      ph++;
    end
  end

  // Monitor: pop and compare on every handshake, hold-check while stalled
  initial begin
    beat_t       e;
    logic        stall;
    logic [31:0] held_d;
    logic [31:0] held_s;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (stall && dump_if.dump_valid_o) begin
        chk("stall_data", dump_if.dump_data_o, held_d);
        chk("stall_sel", 32'(reg_sel), held_s);
      end
      if (dump_if.dump_valid_o && dump_if.dump_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(dump_if.dump_valid_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d_data", beats_seen), dump_if.dump_data_o, e.data);
          chk($sformatf("beat%0d_last", beats_seen), 32'(dump_if.dump_last_o), 32'(e.last));
          if (e.is_reg) chk($sformatf("beat%0d_sel", beats_seen), 32'(reg_sel), 32'(e.sel));
          cap_q.push_back(dump_if.dump_data_o);
          beats_seen++;
          if (exp_q.size() == 0) m_state = M_DONE;
        end
      end
      stall  = dump_if.dump_valid_o && !dump_if.dump_ready_i;
      held_d = dump_if.dump_data_o;
      held_s = 32'(reg_sel);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    int n;
    errors = 0; checks = 0; m_state = M_IDLE; m_cnt = 0;
    beats_seen = 0; rdy_mode = 0;
    rstn = 1'b1; pc_valid = 1'b0; pc = '0; arm = 1'b0;
    set_bp(32'h0, 32'h0, 2'b00);
    for (int r = 0; r < int'(NREGS); r++) rf[r] = $urandom;
    rf[0] = 32'h1234_5678;

    // Reset values
    #1 rstn = 1'b0;
    #1;
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_valid", 32'(dump_if.dump_valid_o), 32'd0);
    chk("rst_last", 32'(dump_if.dump_last_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(reg_sel), 32'd0);
    chk("rst_data", dump_if.dump_data_o, 32'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Matching PCs while idle must not trigger
    set_bp(32'h310, 32'h4, 2'b01);
    repeat (4) cycle(1'b1, 32'h310, 1'b0);

    // A: breakpoint at 0x310, always ready
    start_test(0);
    cycle(1'b0, 32'h0, 1'b1);
    run_seq(32'h0, 1'b0, 1200);
    drain(200);
    chk("A_beats", 32'(cap_q.size()), NREGS + 2);
    chk("A_pc", cap_at(0), 32'h0000_0310);
    chk("A_cause", cap_at(1), 32'h00C5_0001);

    // B: re-arm from DONE, backpressure 1,0,0,1, gapped PCs, bp0 disabled
    for (int r = 0; r < int'(NREGS); r++) rf[r] = $urandom;
    rf[0] = 32'hFFFF_FFFF;
    rf[5] = 32'hDEAD_BEEF;
    b = 32'(4 * $urandom_range(20, 60));
    set_bp(b, b, 2'b10);
    start_test(1);
    cycle(1'b0, 32'h0, 1'b1);
    run_seq(32'h0, 1'b1, 1000);
    drain(400);
    chk("B_beats", 32'(cap_q.size()), NREGS + 2);
    chk("B_pc", cap_at(0), b);
    chk("B_reg5", cap_at(7), 32'hDEAD_BEEF);

    // C: watchdog timeout only, random ready
    set_bp(32'h0, 32'h0, 2'b00);
    start_test(2);
    cycle(1'b0, 32'h0, 1'b1);
    run_seq($urandom & 32'h00FF_FFF0, 1'b0, 1100);
    drain(400);
    chk("C_cause", cap_at(1), 32'h03E8_0002);

    // D: breakpoint and timeout on the same PC
    set_bp(32'hDEAD_0000, 32'h0000_0F9C, 2'b11);
    start_test(1);
    cycle(1'b0, 32'h0, 1'b1);
    run_seq(32'h0, 1'b0, 1100);
    drain(400);
    chk("D_cause", cap_at(1), 32'h03E8_0007);

    // E: both comparators match, lowest index wins
    set_bp(32'h40, 32'h40, 2'b11);
    start_test(2);
    cycle(1'b0, 32'h0, 1'b1);
    run_seq(32'h0, 1'b0, 100);
    drain(400);
    chk("E_cause", cap_at(1), 32'h0011_0001);

    // F: arm ignored in DUMP, then reset aborts the stream
    set_bp(32'h20, 32'h0, 2'b01);
    start_test(0);
    cycle(1'b0, 32'h0, 1'b1);
    run_seq(32'h0, 1'b0, 50);
    cycle(1'b1, 32'h20, 1'b1);
    n = 0;
    while (beats_seen < 10 && n < 100) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk("F_reached_beat10", 32'(beats_seen >= 10), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("F_valid", 32'(dump_if.dump_valid_o), 32'd0);
    chk("F_halt", 32'(halt), 32'd0);
    chk("F_busy", 32'(busy), 32'd0);
    chk("F_last", 32'(dump_if.dump_last_o), 32'd0);
    chk("F_sel", 32'(reg_sel), 32'd0);
    chk("F_data", dump_if.dump_data_o, 32'd0);
    exp_q.delete();
    m_state = M_IDLE;
    m_cnt   = 0;
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) cycle(1'b1, 32'h20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
